// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of an 8:1 TDM link; rebuilds one word per frame of serial slots.
// Optional macro TDM_SYNC_CHECK_EN: a missing frame_start at slot 0 drops back to HUNT.
module tdm_demux8 #(
  parameter int SLOTS = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] slot,
  output logic [SLOTS-1:0] dout,
  output logic             dout_valid,
  output logic             sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(SLOTS - 1);

  state_t           state;
  // The last slot bit goes straight into dout, so only SLOTS-1 bits are buffered.
  logic [SLOTS-2:0] cap;

  always_ff @(posedge clk) begin
    // NOTE: strobes default low every cycle and only the branch that fires raises one;
    // all state here uses non-blocking assignments so every branch sees pre-edge values.
    dout_valid <= 1'b0;
    sync_err   <= 1'b0;

    if (rst) begin
      state <= HUNT;
      slot  <= '0;
      cap   <= '0;
      dout  <= '0;
    end else if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_start) begin
            cap[0] <= din;
            slot   <= SEL_W'(1);
            state  <= RECV;
          end
        end

        RECV: begin
          if (frame_start && (slot != '0)) begin
            // Early marker: abandon the partial frame and treat this bit as slot 0.
            sync_err <= 1'b1;
            cap[0]   <= din;
            slot     <= SEL_W'(1);
          end
`ifdef TDM_SYNC_CHECK_EN
          else if (!frame_start && (slot == '0)) begin
            sync_err <= 1'b1;
            slot     <= '0;
            state    <= HUNT;
          end
`endif
          else if (slot == LAST_SLOT) begin
            dout       <= {din, cap};
            dout_valid <= 1'b1;
            slot       <= '0;
          end else begin
            cap[slot] <= din;
            slot      <= slot + SEL_W'(1);
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(dout_valid && sync_err));
  assert property (@(posedge clk) disable iff (rst) slot <= LAST_SLOT);

endmodule
